// File: rtl/vga_fb_ctrl.sv
// vga_fb_ctrl: parametrised VGA timing generator with an internal dual-port
// framebuffer, synchronous write port, integer pixel scaling, packed pixel
// formats and optional vblank-aligned double buffering.
module vga_fb_ctrl #(
    parameter int  H_ACTIVE    = 640,
    parameter int  H_FP        = 16,
    parameter int  H_SYNC      = 96,
    parameter int  H_BP        = 48,
    parameter int  V_ACTIVE    = 480,
    parameter int  V_FP        = 10,
    parameter int  V_SYNC      = 2,
    parameter int  V_BP        = 33,
    parameter int  SCALE_SHIFT = 0,
    parameter int  PIX_W       = 24,
    parameter int  DOUBLE_BUF  = 0,
    localparam int FB_W        = H_ACTIVE >> SCALE_SHIFT,
    localparam int FB_H        = V_ACTIVE >> SCALE_SHIFT,
    localparam int FB_N        = FB_W * FB_H,
    localparam int AW          = $clog2(FB_N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [PIX_W-1:0] wr_data,
    input  logic             swap_req,
    output logic             swap_ack,
    output logic             frame_start,
    output logic             VGA_CLK,
    output logic             VGA_HSYNC,
    output logic             VGA_VSYNC,
    output logic             VGA_BLANK_N,
    output logic [7:0]       VGA_R,
    output logic [7:0]       VGA_G,
    output logic [7:0]       VGA_B
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);
    localparam int NBUF    = (DOUBLE_BUF != 0) ? 2 : 1;
    localparam int DEPTH   = NBUF * FB_N;
    localparam int RAW     = $clog2(DEPTH);

    localparam logic [HW-1:0]  H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0]  H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0]  HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0]  HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0]  V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0]  V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0]  V_SWAP   = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0]  VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0]  VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    // base of buffer 1; only ever added when DOUBLE_BUF=1
    localparam logic [RAW-1:0] BUF_OFS  = RAW'(FB_N);
    localparam logic [RAW-1:0] FB_W_R   = RAW'(FB_W);
    // one extra bit so the bound still works when FB_N is a power of two
    localparam logic [AW:0]    FB_N_LIM = (AW+1)'(FB_N);

    logic [HW-1:0]    r_h_cnt;
    logic [VW-1:0]    r_v_cnt;
    logic             r_front, r_pending;
    logic [PIX_W-1:0] r_mem [DEPTH];
    logic [PIX_W-1:0] r_rd_data;
    logic             r_act1, r_hs1, r_vs1, r_fs1;

    logic             w_active, w_hsync_n, w_vsync_n, w_frame0;
    logic             w_swap_pt, w_swap_req, w_back, w_wr_ok;
    logic [RAW-1:0]   w_rd_addr, w_wr_addr;
    logic [7:0]       w_r, w_g, w_b;

    assign VGA_CLK = clk;

    // S0: raster counters; v advances when h wraps
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    // S0 decode: timing flags, read address (front buffer) and write address (back buffer)
    always_comb begin
        w_active   = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
        w_hsync_n  = !((r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END));
        w_vsync_n  = !((r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END));
        w_frame0   = (r_h_cnt == '0) && (r_v_cnt == '0);
        w_swap_pt  = (r_h_cnt == H_LAST) && (r_v_cnt == V_SWAP);
        w_swap_req = (DOUBLE_BUF != 0) && swap_req;
        w_back     = (DOUBLE_BUF != 0) && !r_front;
        w_wr_ok    = wr_en && ({1'b0, wr_addr} < FB_N_LIM);
        // blanking reads are parked at 0 so the address never leaves the array
        w_rd_addr  = '0;
        if (w_active)
            w_rd_addr = (r_front ? BUF_OFS : '0)
                      + RAW'(r_v_cnt >> SCALE_SHIFT) * FB_W_R
                      + RAW'(r_h_cnt >> SCALE_SHIFT);
        w_wr_addr  = (w_back ? BUF_OFS : '0) + RAW'(wr_addr);
    end

    // S1: dual-port memory; read-before-write gives old data on a collision
    always_ff @(posedge clk) begin
        if (w_wr_ok)
            r_mem[w_wr_addr] <= wr_data;
        r_rd_data <= r_mem[w_rd_addr];
    end

    // S1: timing flags travel alongside the memory read
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_act1 <= 1'b0;
            r_hs1  <= 1'b1;
            r_vs1  <= 1'b1;
            r_fs1  <= 1'b0;
        end else begin
            r_act1 <= w_active;
            r_hs1  <= w_hsync_n;
            r_vs1  <= w_vsync_n;
            r_fs1  <= w_frame0;
        end
    end

    // S2 colour expansion to 8 bits per channel
    generate
        if (PIX_W == 12) begin : g_rgb444
            assign w_r = {r_rd_data[11:8], r_rd_data[11:8]};
            assign w_g = {r_rd_data[7:4],  r_rd_data[7:4]};
            assign w_b = {r_rd_data[3:0],  r_rd_data[3:0]};
        end else if (PIX_W == 16) begin : g_rgb565
            assign w_r = {r_rd_data[15:11], r_rd_data[15:13]};
            assign w_g = {r_rd_data[10:5],  r_rd_data[10:9]};
            assign w_b = {r_rd_data[4:0],   r_rd_data[4:2]};
        end else begin : g_rgb888
            assign w_r = r_rd_data[23:16];
            assign w_g = r_rd_data[15:8];
            assign w_b = r_rd_data[7:0];
        end
    endgenerate

    // S2: output registers, colour forced to black outside the active area
    always_ff @(posedge clk) begin
        if (!rst) begin
            VGA_HSYNC   <= 1'b1;
            VGA_VSYNC   <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            frame_start <= 1'b0;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
        end else begin
            VGA_HSYNC   <= r_hs1;
            VGA_VSYNC   <= r_vs1;
            VGA_BLANK_N <= r_act1;
            frame_start <= r_fs1;
            VGA_R       <= r_act1 ? w_r : 8'h00;
            VGA_G       <= r_act1 ? w_g : 8'h00;
            VGA_B       <= r_act1 ? w_b : 8'h00;
        end
    end

    // swap control: requests coalesce into one pending flag, honoured only
    // after the last active line so a frame never mixes buffers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_front   <= 1'b0;
            r_pending <= 1'b0;
            swap_ack  <= 1'b0;
        end else begin
            swap_ack <= 1'b0;
            if (w_swap_pt && (r_pending || w_swap_req)) begin
                r_front   <= ~r_front;
                r_pending <= 1'b0;
                swap_ack  <= 1'b1;
            end else if (w_swap_req) begin
                r_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_fb_ctrl.sv
// Directed bench for vga_fb_ctrl on a reduced 16x10 raster (8x6 active).
// u_a: RGB565, 2x scaling, double buffered; u_b: RGB888 unscaled single
// buffer; u_c: RGB444, 2x scaling, single buffer.
module tb_vga_fb_ctrl;
    localparam int HT  = 16;
    localparam int FRM = 160;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        a_we = 1'b0, a_sreq = 1'b0;
    logic [3:0]  a_wa = '0;
    logic [15:0] a_wd = '0;
    logic        a_sack, a_fs, a_vclk, a_hs, a_vs, a_bn;
    logic [7:0]  a_r, a_g, a_b;
    logic        b_we = 1'b0, b_sreq = 1'b0;
    logic [5:0]  b_wa = '0;
    logic [23:0] b_wd = '0;
    logic        b_sack, b_fs, b_vclk, b_hs, b_vs, b_bn;
    logic [7:0]  b_r, b_g, b_b;
    logic        c_we = 1'b0, c_sreq = 1'b0;
    logic [3:0]  c_wa = '0;
    logic [11:0] c_wd = '0;
    logic        c_sack, c_fs, c_vclk, c_hs, c_vs, c_bn;
    logic [7:0]  c_r, c_g, c_b;

    vga_fb_ctrl #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
                  .SCALE_SHIFT(1), .PIX_W(16), .DOUBLE_BUF(1)) u_a (
        .clk(clk), .rst(rst), .wr_en(a_we), .wr_addr(a_wa), .wr_data(a_wd), .swap_req(a_sreq),
        .swap_ack(a_sack), .frame_start(a_fs), .VGA_CLK(a_vclk), .VGA_HSYNC(a_hs), .VGA_VSYNC(a_vs),
        .VGA_BLANK_N(a_bn), .VGA_R(a_r), .VGA_G(a_g), .VGA_B(a_b));

    vga_fb_ctrl #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
                  .SCALE_SHIFT(0), .PIX_W(24), .DOUBLE_BUF(0)) u_b (
        .clk(clk), .rst(rst), .wr_en(b_we), .wr_addr(b_wa), .wr_data(b_wd), .swap_req(b_sreq),
        .swap_ack(b_sack), .frame_start(b_fs), .VGA_CLK(b_vclk), .VGA_HSYNC(b_hs), .VGA_VSYNC(b_vs),
        .VGA_BLANK_N(b_bn), .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b));

    vga_fb_ctrl #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
                  .SCALE_SHIFT(1), .PIX_W(12), .DOUBLE_BUF(0)) u_c (
        .clk(clk), .rst(rst), .wr_en(c_we), .wr_addr(c_wa), .wr_data(c_wd), .swap_req(c_sreq),
        .swap_ack(c_sack), .frame_start(c_fs), .VGA_CLK(c_vclk), .VGA_HSYNC(c_hs), .VGA_VSYNC(c_vs),
        .VGA_BLANK_N(c_bn), .VGA_R(c_r), .VGA_G(c_g), .VGA_B(c_b));

    int n_chk = 0, n_err = 0;
    int cyc = 0;                       // raster position of the DUT counters
    int a_acks = 0, a_ack_pos = -1, nb_acks = 0;
    int fs_last = 0, fs_prev = 0;
    int hs_lo, vs_lo, bn_hi, fs_n;
    logic [15:0] ma [24];              // u_a: buffer 0 at 0..11, buffer 1 at 12..23
    logic [23:0] mb [48];
    logic [11:0] mc [12];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] e565(input logic [15:0] p);
        return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
    endfunction

    function automatic logic [23:0] e444(input logic [11:0] p);
        return {p[11:8], p[11:8], p[7:4], p[7:4], p[3:0], p[3:0]};
    endfunction

    task automatic tick;
        @(negedge clk);
        cyc++;
        if (a_sack) begin a_acks++; a_ack_pos = cyc % FRM; end
        if (b_sack || c_sack) nb_acks++;
        if (b_fs) begin fs_prev = fs_last; fs_last = cyc; end
    endtask

    // outputs show pixel p (2-cycle pipeline)
    task automatic wait_out(input int p);
        for (int i = 0; i < 2*FRM && !((cyc >= 2) && (((cyc - 2) % FRM) == p)); i++) tick();
    endtask

    // counters sit at pixel p
    task automatic wait_cnt(input int p);
        for (int i = 0; i < 2*FRM && ((cyc % FRM) != p); i++) tick();
    endtask

    task automatic wr_a(input int ad, input logic [15:0] d);
        a_we = 1'b1; a_wa = 4'(ad); a_wd = d; tick(); a_we = 1'b0;
    endtask
    task automatic wr_b(input int ad, input logic [23:0] d);
        b_we = 1'b1; b_wa = 6'(ad); b_wd = d; tick(); b_we = 1'b0;
    endtask
    task automatic wr_c(input int ad, input logic [11:0] d);
        c_we = 1'b1; c_wa = 4'(ad); c_wd = d; tick(); c_we = 1'b0;
    endtask

    // one-cycle reset from the current negedge, then check the restart
    task automatic do_reset;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_A", 32'({a_hs, a_vs, a_bn, a_fs, a_sack, a_r, a_g, a_b}), 32'h1800_0000);
        chk("rst_B", 32'({b_hs, b_vs, b_bn, b_fs, b_sack, b_r, b_g, b_b}), 32'h1800_0000);
        chk("rst_C", 32'({c_hs, c_vs, c_bn, c_fs, c_sack, c_r, c_g, c_b}), 32'h1800_0000);
        rst = 1'b1;
        cyc = 0;
        tick();
        chk("fs_cyc1", 32'({a_fs, b_fs, c_fs}), 32'h0);
        tick();
        chk("fs_cyc2", 32'({a_fs, b_fs, c_fs}), 32'h7);
    endtask

    // full-frame readback of all three instances against the bench images
    task automatic frame_chk(input string tag, input int abuf, input bit sreq);
        int et, ea, eb, ec, h, v;
        logic bn, hs, vs, f0;
        logic [23:0] xa, xb, xc;
        et = 0; ea = 0; eb = 0; ec = 0;
        hs_lo = 0; vs_lo = 0; bn_hi = 0; fs_n = 0;
        wait_out(0);
        for (int p = 0; p < FRM; p++) begin
            h  = p % HT;
            v  = p / HT;
            bn = (h < 8) && (v < 6);
            hs = !((h >= 10) && (h < 13));
            vs = !((v >= 7) && (v < 9));
            f0 = (p == 0);
            xa = 24'h0; xb = 24'h0; xc = 24'h0;
            if (bn) begin
                xa = e565(ma[abuf*12 + (v/2)*4 + h/2]);
                xb = mb[v*8 + h];
                xc = e444(mc[(v/2)*4 + h/2]);
            end
            if ({a_hs, a_vs, a_bn, a_fs} !== {hs, vs, bn, f0}) et++;
            if ({b_hs, b_vs, b_bn, b_fs} !== {hs, vs, bn, f0}) et++;
            if ({c_hs, c_vs, c_bn, c_fs} !== {hs, vs, bn, f0}) et++;
            if ({a_r, a_g, a_b} !== xa) ea++;
            if ({b_r, b_g, b_b} !== xb) eb++;
            if ({c_r, c_g, c_b} !== xc) ec++;
            if (!b_hs) hs_lo++;
            if (!b_vs) vs_lo++;
            if (b_bn)  bn_hi++;
            if (b_fs)  fs_n++;
            if (sreq && (p == 40 || p == 60)) a_sreq = 1'b1;
            tick();
            a_sreq = 1'b0;
        end
        chk({tag, "_timing"}, et, 0);
        chk({tag, "_imgA"}, ea, 0);
        chk({tag, "_imgB"}, eb, 0);
        chk({tag, "_imgC"}, ec, 0);
    endtask

    initial begin
        for (int i = 0; i < 24; i++) ma[i] = (i < 12) ? 16'hF800 : 16'h001F;
        ma[12] = 16'h07E0; ma[18] = 16'hF81F; ma[23] = 16'h8410;
        for (int i = 0; i < 48; i++) mb[i] = {8'(i*5), 8'hA0 ^ 8'(i), 8'(255 - i)};
        mb[0] = 24'h123456;
        for (int i = 0; i < 12; i++) mc[i] = {4'(i), 4'(15 - i), 4'(i)};
        mc[0] = 12'h3C9;

        repeat (3) @(negedge clk);
        do_reset();
        chk("vga_clk", 32'({a_vclk, b_vclk, c_vclk}), 32'h0);

        // front=0 after reset, so u_a writes land in buffer 1
        for (int i = 0; i < 12; i++) wr_a(i, ma[12 + i]);
        for (int i = 0; i < 48; i++) wr_b(i, mb[i]);
        for (int i = 0; i < 12; i++) wr_c(i, mc[i]);

        a_sreq = 1'b1; tick(); a_sreq = 1'b0;
        for (int i = 0; i < 2*FRM && a_acks < 1; i++) tick();
        chk("ack_first", a_acks, 1);
        chk("ack_pos1", a_ack_pos, 96);

        // buffer 0 is now the back buffer: fill it red
        for (int i = 0; i < 12; i++) wr_a(i, ma[i]);

        // out-of-range writes must be dropped; swap requests ignored on single buffer
        wr_a(12, 16'h1234); wr_a(15, 16'h5678);
        wr_b(48, 24'hDEAD00); wr_b(63, 24'hBEEF00);
        wr_c(12, 12'hABC); wr_c(15, 12'h123);
        b_sreq = 1'b1; c_sreq = 1'b1; tick(); b_sreq = 1'b0; c_sreq = 1'b0;

        // directed pixels
        wait_out(0);
        chk("a_px00", 32'({a_r, a_g, a_b}), 32'h00FF00);
        chk("b_px00", 32'({b_r, b_g, b_b}), 32'h123456);
        wait_out(1);  chk("a_px10", 32'({a_r, a_g, a_b}), 32'h00FF00);
        wait_out(2);
        chk("a_px20", 32'({a_r, a_g, a_b}), 32'h0000FF);
        chk("c_px20", 32'({c_r, c_g, c_b}), 32'h11EE11);
        wait_out(16); chk("a_px01", 32'({a_r, a_g, a_b}), 32'h00FF00);
        wait_out(17);
        chk("a_px11", 32'({a_r, a_g, a_b}), 32'h00FF00);
        chk("c_px11", 32'({c_r, c_g, c_b}), 32'h33CC99);
        wait_out(36); chk("a_565_px42", 32'({a_r, a_g, a_b}), 32'hFF00FF);
        wait_out(38); chk("a_nbr_px62", 32'({a_r, a_g, a_b}), 32'h0000FF);
        wait_out(53); chk("a_565_px53", 32'({a_r, a_g, a_b}), 32'hFF00FF);
        wait_out(70); chk("a_565_px64", 32'({a_r, a_g, a_b}), 32'h848284);

        // latency: counters at (3,2), colour shows exactly two clocks later
        wait_cnt(35);
        tick(); chk("b_lat1", 32'({b_r, b_g, b_b}), 32'h5AB2ED);
        tick(); chk("b_lat2", 32'({b_r, b_g, b_b}), 32'h5FB3EC);

        // same-cycle read and write of pixel (5,1) returns old data
        wait_cnt(21);
        b_we = 1'b1; b_wa = 6'd13; b_wd = 24'hC0FFEE; tick(); b_we = 1'b0;
        tick();
        chk("b_rdw_old", 32'({b_r, b_g, b_b}), 32'h41ADF2);
        mb[13] = 24'hC0FFEE;

        frame_chk("img", 1, 1'b0);
        chk("hsync_lo", hs_lo, 30);
        chk("vsync_lo", vs_lo, 32);
        chk("blank_hi", bn_hi, 48);
        chk("fs_count", fs_n, 1);

        // two requests mid-frame: current frame untouched, one ack only
        frame_chk("swapreq", 1, 1'b1);
        chk("coalesce", a_acks, 2);
        chk("ack_pos2", a_ack_pos, 96);
        chk("fs_period", fs_last - fs_prev, FRM);
        frame_chk("newbuf", 0, 1'b0);

        // request arriving on the swap-point cycle itself
        wait_cnt(95);
        a_sreq = 1'b1; tick(); a_sreq = 1'b0;
        chk("edge_req", a_acks, 3);
        chk("ack_pos3", a_ack_pos, 96);
        frame_chk("edgebuf", 1, 1'b0);

        // reset mid-frame at counters (5,3); images must survive
        wait_cnt(53);
        do_reset();
        frame_chk("postrst0", 0, 1'b0);
        a_sreq = 1'b1; tick(); a_sreq = 1'b0;
        for (int i = 0; i < 2*FRM && a_acks < 4; i++) tick();
        chk("ack_postrst", a_acks, 4);
        frame_chk("postrst1", 1, 1'b0);
        chk("single_noack", nb_acks, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
